// File: rtl/cut_agc_ctl.sv
// cut_agc_ctl: frame-based gain controller for the 32-to-16-bit I/Q truncation stage.
// It counts saturated samples and tracks peak magnitude over each frame. At every
// frame boundary it picks the truncation setting for the next frame. With agc_en low
// it passes the manual setting straight through.
module cut_agc_ctl #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SAT_HI    = 8,
  parameter logic [15:0] PEAK_LO   = 16'h3000,
  parameter int unsigned INIT_GAIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      din_i,
  input  logic [15:0]      din_q,
  input  logic             din_valid,
  input  logic             agc_en,
  input  logic [2:0]       man_cut_ctl,
  output logic [2:0]       cut_ctl_out,
  output logic [2:0]       gain_idx,
  output logic [CNT_W-1:0] sat_cnt_last,
  output logic [15:0]      peak_last,
  output logic             frame_done
);

  localparam int unsigned DW = 16;
  localparam int unsigned GW = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SAT_HI_C = CNT_W'(SAT_HI);
  localparam logic [GW-1:0]    INIT_G   = GW'(INIT_GAIN);
  localparam logic [GW-1:0]    G_MAX    = 3'd7;
  localparam logic [DW-1:0]    POS_FS   = 16'h7fff;
  localparam logic [DW-1:0]    NEG_FS   = 16'h8000;

  // Gain index to truncation setting: ladder is 7,0,1,...,6 from least to most gain.
  function automatic logic [GW-1:0] f_map(input logic [GW-1:0] g);
    return (g == 3'd0) ? 3'd7 : g - 3'd1;
  endfunction

  // Truncation setting back to gain index.
  function automatic logic [GW-1:0] f_inv(input logic [GW-1:0] c);
    return (c == 3'd7) ? 3'd0 : c + 3'd1;
  endfunction

  // Unsigned magnitude of a signed sample; full-scale negative maps to 16'h8000.
  function automatic logic [DW-1:0] f_mag(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + 16'd1) : x;
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_sat_acc;
  logic [DW-1:0]    r_peak_acc;
  logic [CNT_W-1:0] r_snap_sat;
  logic [DW-1:0]    r_snap_peak;

  logic [GW-1:0]    r_gain;
  logic [GW-1:0]    r_cut;
  logic [CNT_W-1:0] r_sat_last;
  logic [DW-1:0]    r_peak_last;
  logic             r_done;

  logic             w_sat_smp;
  logic [DW-1:0]    w_mag_i;
  logic [DW-1:0]    w_mag_q;
  logic [DW-1:0]    w_peak_smp;
  logic [DW-1:0]    w_peak_nxt;
  logic [CNT_W-1:0] w_sat_nxt;
  logic             w_counting;
  logic             w_last;
  logic             w_step_dn;
  logic             w_step_up;
  logic [GW-1:0]    w_gain_dec;

  // Per-sample statistics: saturation flag and running peak including this sample.
  always_comb begin
    w_sat_smp  = (din_i == POS_FS) || (din_i == NEG_FS) ||
                 (din_q == POS_FS) || (din_q == NEG_FS);
    w_mag_i    = f_mag(din_i);
    w_mag_q    = f_mag(din_q);
    w_peak_smp = (w_mag_i > w_mag_q) ? w_mag_i : w_mag_q;
    w_peak_nxt = (w_peak_smp > r_peak_acc) ? w_peak_smp : r_peak_acc;
    w_sat_nxt  = r_sat_acc;
    if (w_sat_smp && !(&r_sat_acc)) begin
      w_sat_nxt = r_sat_acc + CNT_W'(1);
    end
  end

  // Samples are gathered in ACCUM and also in DECIDE, where they open the next frame.
  always_comb begin
    w_counting = agc_en && din_valid &&
                 ((r_state == S_ACCUM) || (r_state == S_DECIDE));
    w_last     = agc_en && din_valid && (r_state == S_ACCUM) && (r_cnt == LAST_IDX);
  end

  // Frame decision: back off on heavy saturation, otherwise step up on a quiet frame.
  always_comb begin
    w_step_dn  = (r_snap_sat > SAT_HI_C) && (r_gain != 3'd0);
    w_step_up  = (r_snap_sat == '0) && (r_snap_peak < PEAK_LO) && (r_gain != G_MAX);
    w_gain_dec = r_gain;
    if (w_step_dn) begin
      w_gain_dec = r_gain - 3'd1;
    end else if (w_step_up) begin
      w_gain_dec = r_gain + 3'd1;
    end
  end

  // Next-state logic; dropping agc_en always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!agc_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_ACCUM;
        S_ACCUM:  if (w_last) w_state_nxt = S_DECIDE;
        S_DECIDE: w_state_nxt = S_ACCUM;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register; reset lands directly in the mode selected by agc_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= agc_en ? S_ACCUM : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame accumulators and end-of-frame snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_sat_acc   <= '0;
      r_peak_acc  <= '0;
      r_snap_sat  <= '0;
      r_snap_peak <= '0;
    end else if (!agc_en || (r_state == S_IDLE)) begin
      r_cnt      <= '0;
      r_sat_acc  <= '0;
      r_peak_acc <= '0;
    end else if (w_last) begin
      r_snap_sat  <= w_sat_nxt;
      r_snap_peak <= w_peak_nxt;
      r_cnt       <= '0;
      r_sat_acc   <= '0;
      r_peak_acc  <= '0;
    end else if (w_counting) begin
      r_cnt      <= r_cnt + CNT_W'(1);
      r_sat_acc  <= w_sat_nxt;
      r_peak_acc <= w_peak_nxt;
    end
  end

  // Registered decision outputs: manual tracking in IDLE, one update per frame in DECIDE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain      <= INIT_G;
      r_cut       <= f_map(INIT_G);
      r_sat_last  <= '0;
      r_peak_last <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cut  <= man_cut_ctl;
        r_gain <= f_inv(man_cut_ctl);
      end else if ((r_state == S_DECIDE) && agc_en) begin
        r_gain      <= w_gain_dec;
        r_cut       <= f_map(w_gain_dec);
        r_sat_last  <= r_snap_sat;
        r_peak_last <= r_snap_peak;
        r_done      <= 1'b1;
      end
    end
  end

  assign cut_ctl_out  = r_cut;
  assign gain_idx     = r_gain;
  assign sat_cnt_last = r_sat_last;
  assign peak_last    = r_peak_last;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_cut_agc_ctl.sv
// Bench for cut_agc_ctl: a frame-level reference model checked every cycle, plus
// directed frames with hand-computed gain, peak and saturation expectations.
module tb_cut_agc_ctl;

  localparam int FL     = 16;
  localparam int SATHI  = 8;
  localparam int PEAKLO = 'h3000;
  localparam int INITG  = 0;
  localparam int SATMAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din_i;
  logic [15:0] din_q;
  logic        din_valid;
  logic        agc_en;
  logic [2:0]  man_cut_ctl;
  logic [2:0]  cut_ctl_out;
  logic [2:0]  gain_idx;
  logic [15:0] sat_cnt_last;
  logic [15:0] peak_last;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;
  int pulses[$];

  cut_agc_ctl #(
    .FRAME_LEN(FL), .CNT_W(16), .SAT_HI(SATHI), .PEAK_LO(16'h3000), .INIT_GAIN(INITG)
  ) dut (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .din_valid(din_valid),
    .agc_en(agc_en), .man_cut_ctl(man_cut_ctl), .cut_ctl_out(cut_ctl_out),
    .gain_idx(gain_idx), .sat_cnt_last(sat_cnt_last), .peak_last(peak_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state: mode 0 = manual, 1 = collecting, 2 = deciding.
  int ladder [8] = '{7, 0, 1, 2, 3, 4, 5, 6};
  int m_mode, m_n, m_sats, m_pk, m_ssnap, m_psnap;
  int m_gain, m_cut, m_sat_last, m_peak_last, m_done;

  function automatic int mag(input logic [15:0] x);
    int v;
    v = $signed(x);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int gain_of(input int c);
    for (int g = 0; g < 8; g++) if (ladder[g] == c) return g;
    return 0;
  endfunction

  task automatic model_clear();
    m_n = 0; m_sats = 0; m_pk = 0;
  endtask

  task automatic model_step();
    int vi, vq, mi, mq;
    if (rst) begin
      m_gain = INITG; m_cut = ladder[INITG];
      m_sat_last = 0; m_peak_last = 0; m_done = 0;
      m_ssnap = 0; m_psnap = 0;
      model_clear();
      m_mode = agc_en ? 1 : 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        m_cut  = int'(man_cut_ctl);
        m_gain = gain_of(m_cut);
      end else if (m_mode == 2 && agc_en) begin
        if (m_ssnap > SATHI && m_gain > 0) m_gain = m_gain - 1;
        else if (m_ssnap == 0 && m_psnap < PEAKLO && m_gain < 7) m_gain = m_gain + 1;
        m_cut = ladder[m_gain];
        m_sat_last = m_ssnap; m_peak_last = m_psnap; m_done = 1;
      end
      if (!agc_en) begin
        m_mode = 0; model_clear();
      end else if (m_mode == 0) begin
        m_mode = 1; model_clear();
      end else begin
        if (din_valid) begin
          vi = $signed(din_i); vq = $signed(din_q);
          if ((vi == 32767 || vi == -32768 || vq == 32767 || vq == -32768) && m_sats < SATMAX)
            m_sats = m_sats + 1;
          mi = mag(din_i); mq = mag(din_q);
          if (mi > m_pk) m_pk = mi;
          if (mq > m_pk) m_pk = mq;
          m_n = m_n + 1;
        end
        if (m_mode == 1 && din_valid && m_n == FL) begin
          m_ssnap = m_sats; m_psnap = m_pk;
          model_clear();
          m_mode = 2;
        end else begin
          m_mode = 1;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model advances on each active edge.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (frame_done) pulses.push_back(cyc);
    if (chk_on) begin
      cmp("model_gain_idx",     int'(gain_idx),     m_gain);
      cmp("model_cut_ctl_out",  int'(cut_ctl_out),  m_cut);
      cmp("model_sat_cnt_last", int'(sat_cnt_last), m_sat_last);
      cmp("model_peak_last",    int'(peak_last),    m_peak_last);
      cmp("model_frame_done",   int'(frame_done),   m_done);
    end
  end

  task automatic send(input logic v, input logic [15:0] i, input logic [15:0] q);
    din_valid = v; din_i = i; din_q = q;
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int k = 0; k < n; k++) send(1'b0, 16'h0000, 16'h0000);
  endtask

  // Full frame: first nsat samples at positive full scale on I, the rest at iv/qv.
  task automatic frame(input int nsat, input logic [15:0] iv, input logic [15:0] qv);
    for (int k = 0; k < FL; k++) send(1'b1, (k < nsat) ? 16'h7fff : iv, qv);
    idles(3);
  endtask

  // Full frame whose first sample is (fi,fq) and whose remaining samples are zero.
  task automatic frame1(input logic [15:0] fi, input logic [15:0] fq);
    send(1'b1, fi, fq);
    for (int k = 1; k < FL; k++) send(1'b1, 16'h0000, 16'h0000);
    idles(3);
  endtask

  initial begin
    int p0;
    rst = 1'b1; agc_en = 1'b1; man_cut_ctl = 3'd0;
    din_valid = 1'b0; din_i = '0; din_q = '0;
    idles(2);
    rst = 1'b0;
    chk_on = 1'b1;
    cmp("reset_gain", int'(gain_idx), 0);
    cmp("reset_cut", int'(cut_ctl_out), 7);
    cmp("reset_done", int'(frame_done), 0);
    cmp("reset_sat_last", int'(sat_cnt_last), 0);
    cmp("reset_peak_last", int'(peak_last), 0);

    // Quiet frames climb the ladder and clamp at the top.
    for (int k = 1; k <= 8; k++) begin
      frame(0, 16'h0100, 16'h0000);
      cmp("ramp_gain", int'(gain_idx), (k > 7) ? 7 : k);
      cmp("ramp_cut", int'(cut_ctl_out), (k > 7) ? 6 : k - 1);
    end
    cmp("ramp_peak", int'(peak_last), 'h0100);
    cmp("ramp_sat", int'(sat_cnt_last), 0);
    cmp("ramp_pulses", pulses.size(), 8);

    // Manual setting 2 puts gain at 3, then saturation thresholds.
    agc_en = 1'b0; man_cut_ctl = 3'd2;
    idles(2);
    cmp("man2_cut", int'(cut_ctl_out), 2);
    cmp("man2_gain", int'(gain_idx), 3);
    agc_en = 1'b1;
    idles(1);
    frame(9, 16'h0100, 16'h0000);
    cmp("sat9_gain", int'(gain_idx), 2);
    cmp("sat9_cut", int'(cut_ctl_out), 1);
    cmp("sat9_sat_last", int'(sat_cnt_last), 9);
    cmp("sat9_peak", int'(peak_last), 'h7fff);
    frame(8, 16'h0100, 16'h0000);
    cmp("sat8_gain", int'(gain_idx), 2);
    cmp("sat8_sat_last", int'(sat_cnt_last), 8);

    // Double full-scale negative is one saturated sample with peak 0x8000.
    frame1(16'h8000, 16'h8000);
    cmp("neg_fs_sat", int'(sat_cnt_last), 1);
    cmp("neg_fs_peak", int'(peak_last), 'h8000);
    cmp("neg_fs_gain", int'(gain_idx), 2);
    frame1(16'h3000, 16'h0000);
    cmp("peak_eq_lo_gain", int'(gain_idx), 2);
    frame1(16'h2fff, 16'h0000);
    cmp("peak_below_lo_gain", int'(gain_idx), 3);
    frame1(16'h0000, 16'hd001);
    cmp("neg_q_peak", int'(peak_last), 'h2fff);
    cmp("neg_q_gain", int'(gain_idx), 4);

    // Manual override then bumpless return to automatic.
    p0 = pulses.size();
    agc_en = 1'b0; man_cut_ctl = 3'd4;
    idles(2);
    cmp("man4_cut", int'(cut_ctl_out), 4);
    cmp("man4_gain", int'(gain_idx), 5);
    cmp("man4_no_pulse", pulses.size(), p0);
    agc_en = 1'b1;
    idles(1);
    frame(0, 16'h0100, 16'h0000);
    cmp("auto_from5_gain", int'(gain_idx), 6);
    cmp("auto_from5_cut", int'(cut_ctl_out), 5);

    // Partial frame abandoned by agc_en drop: history retained, no decision.
    p0 = pulses.size();
    for (int k = 0; k < 5; k++) send(1'b1, 16'h7fff, 16'h0000);
    agc_en = 1'b0;
    idles(2);
    cmp("abort_sat_last", int'(sat_cnt_last), 0);
    cmp("abort_no_pulse", pulses.size(), p0);
    cmp("abort_gain", int'(gain_idx), 5);
    agc_en = 1'b1;
    idles(1);

    // Reset mid-frame: the next frame needs a full FL samples.
    for (int k = 0; k < 10; k++) send(1'b1, 16'h0100, 16'h0000);
    rst = 1'b1;
    idles(1);
    rst = 1'b0;
    cmp("midrst_gain", int'(gain_idx), 0);
    cmp("midrst_cut", int'(cut_ctl_out), 7);
    p0 = pulses.size();
    for (int k = 0; k < FL - 1; k++) send(1'b1, 16'h0100, 16'h0000);
    idles(2);
    cmp("midrst_no_early_pulse", pulses.size(), p0);
    send(1'b1, 16'h0100, 16'h0000);
    idles(2);
    cmp("midrst_pulse", pulses.size(), p0 + 1);
    cmp("midrst_gain_after", int'(gain_idx), 1);

    // Continuous stream: the sample landing in DECIDE opens the next frame.
    p0 = pulses.size();
    for (int k = 0; k < 2 * FL; k++) send(1'b1, 16'h0100, 16'h0000);
    idles(3);
    cmp("stream_pulses", pulses.size(), p0 + 2);
    if (pulses.size() >= p0 + 2)
      cmp("stream_spacing", pulses[p0 + 1] - pulses[p0], FL);
    cmp("stream_gain", int'(gain_idx), 3);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
